tlp_capture_pack: RTL and testbench

TLP_CAPTURE_PACK -- requirements
Module: tlp_capture_pack

---
 rtl/tlp_capture_pack.sv | 204 ++++++++++++++++++++
 tb/tb_tlp_capture_pack.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_capture_pack.sv
// tlp_capture_pack: captures AXI-Stream TLPs into a fixed-size record of
// TLP_WORDS 64-bit words and writes each record into a FIFO on consecutive
// cycles, so the reader can drain a whole record without checking empty.
//
// Build option: define TLP_DROP_ON_FULL_EN to discard a completed TLP when
// the FIFO lacks room, instead of holding off the stream until it drains.
//
// FIFO record word: din = {tkeep[7:0], tdata[63:0], tlast, tuser}
//
// state | meaning
// ------+-----------------------------------------------------------
// CAP   | accept beats into the slot buffer (tready high after reset)
// WRITE | emit the buffered record, one slot per cycle, slot 0 first
// WAIT  | record complete, FIFO has fewer than TLP_WORDS free entries
module tlp_capture_pack #(
  parameter int TLP_WORDS = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk156,
  input  logic             sys_rst_n,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             wr_en,
  output logic [73:0]      din,
  input  logic             prog_full,
  output logic [CNT_W-1:0] cap_count,
  output logic [CNT_W-1:0] trunc_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int BW = $clog2(TLP_WORDS + 1);
  localparam int WW = (TLP_WORDS > 1) ? $clog2(TLP_WORDS) : 1;
  localparam logic [BW-1:0] SLOTS   = BW'(TLP_WORDS);
  localparam logic [WW-1:0] WR_LOAD = WW'(TLP_WORDS - 1);

  typedef enum logic [1:0] {
    CAP   = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          run_q;
  logic [BW-1:0] beat_q;
  logic [WW-1:0] wr_left_q;
  logic          err_q;
  logic          trunc_q;
  logic [63:0]   slot_q [TLP_WORDS];

  logic          accept;
  logic          beat_over;
  logic          last_wr;
  logic          drop_tlp;
  logic [63:0]   beat_masked;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign beat_over = (beat_q >= SLOTS);
  assign last_wr   = (state_q == WRITE) && (wr_left_q == '0);

`ifdef TLP_DROP_ON_FULL_EN
  logic [CNT_W-1:0] drop_q;

  assign drop_tlp   = prog_full;
  assign drop_count = drop_q;

  // Count TLPs discarded because the FIFO could not take a whole record.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drop_q <= '0;
    end else if (accept && s_axis_tlast && prog_full) begin
      drop_q <= drop_q + 1'b1;
    end
  end
`else
  assign drop_tlp   = 1'b0;
  assign drop_count = '0;
`endif

  // Zero the bytes whose keep bit is clear before they enter the buffer.
  always_comb begin
    beat_masked = '0;
    for (int b = 0; b < 8; b++) begin
      if (s_axis_tkeep[b]) begin
        beat_masked[8*b +: 8] = s_axis_tdata[8*b +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= CAP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/strobe outputs; tready is held low until the
  // first clock after reset release via run_q.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    wr_en         = 1'b0;
    unique case (state_q)
      CAP: begin
        s_axis_tready = run_q;
        if (run_q && s_axis_tvalid && s_axis_tlast) begin
`ifdef TLP_DROP_ON_FULL_EN
          if (!prog_full) begin
            state_d = WRITE;
          end
`else
          state_d = prog_full ? WAIT : WRITE;
`endif
        end
      end
      WAIT: begin
        if (!prog_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en = 1'b1;
        if (wr_left_q == '0) begin
          state_d = CAP;
        end
      end
      default: state_d = CAP;
    endcase
  end

  // Record word: keep is always all-ones; tlast/tuser only on the final slot.
  assign din = wr_en ? {8'hFF, slot_q[0], last_wr, last_wr & (err_q | trunc_q)} : '0;

  // Slot buffer, beat index, error/truncation flags and record counters.
  // The buffer shifts toward slot 0 while writing and refills with zeros,
  // so it is already clear when the state returns to CAP.
  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q       <= 1'b0;
      beat_q      <= '0;
      wr_left_q   <= WR_LOAD;
      err_q       <= 1'b0;
      trunc_q     <= 1'b0;
      cap_count   <= '0;
      trunc_count <= '0;
      for (int i = 0; i < TLP_WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;

      if (accept) begin
        if (beat_over) begin
          trunc_q <= 1'b1;
        end else begin
          for (int i = 0; i < TLP_WORDS; i++) begin
            if (beat_q == BW'(i)) begin
              slot_q[i] <= beat_masked;
            end
          end
          beat_q <= beat_q + 1'b1;
        end
        if (s_axis_tuser) begin
          err_q <= 1'b1;
        end
        if (s_axis_tlast) begin
          beat_q <= '0;
          if (trunc_q || beat_over) begin
            trunc_count <= trunc_count + 1'b1;
          end
          if (drop_tlp) begin
            err_q   <= 1'b0;
            trunc_q <= 1'b0;
            for (int i = 0; i < TLP_WORDS; i++) begin
              slot_q[i] <= '0;
            end
          end
        end
      end

      if (wr_en) begin
        for (int i = 0; i < TLP_WORDS - 1; i++) begin
          slot_q[i] <= slot_q[i+1];
        end
        slot_q[TLP_WORDS-1] <= '0;
        if (last_wr) begin
          wr_left_q <= WR_LOAD;
          err_q     <= 1'b0;
          trunc_q   <= 1'b0;
          cap_count <= cap_count + 1'b1;
        end else begin
          wr_left_q <= wr_left_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlp_capture_pack.sv
// Testbench for tlp_capture_pack: a driver issues TLPs and pushes the
// expected FIFO record words into a queue; a monitor pops and compares on
// every wr_en. Follows TLP_DROP_ON_FULL_EN if defined for the build.
module tb_tlp_capture_pack;

  localparam int TW = 4;
  localparam int CW = 32;
`ifdef TLP_DROP_ON_FULL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk156;
  logic          sys_rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [63:0]   s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic          wr_en;
  logic [73:0]   din;
  logic          prog_full;
  logic [CW-1:0] cap_count;
  logic [CW-1:0] trunc_count;
  logic [CW-1:0] drop_count;

  tlp_capture_pack #(.TLP_WORDS(TW), .CNT_W(CW)) dut (
    .clk156        (clk156),
    .sys_rst_n     (sys_rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .wr_en         (wr_en),
    .din           (din),
    .prog_full     (prog_full),
    .cap_count     (cap_count),
    .trunc_count   (trunc_count),
    .drop_count    (drop_count)
  );

  initial clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [73:0] exp_q [$];
  int mon_pos = 0;
  logic [CW-1:0] cap_exp = '0;
  logic [CW-1:0] trunc_exp = '0;
  logic [CW-1:0] drop_exp = '0;
  bit pf_rand = 1'b0;

  logic [63:0] bd [16];
  logic [7:0]  bk [16];
  logic        bu [16];

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_beat(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (k[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Monitor: every write must match the next expected word, and a record
  // must be written on consecutive cycles.
  initial begin
    logic [73:0] exp_w;
    forever begin
      @(negedge clk156);
      if (sys_rst_n) begin
        if (wr_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write actual=%0h required=no write", din);
          end else begin
            exp_w = exp_q.pop_front();
            if (din !== exp_w) begin
              errors++;
              $display("FAIL record_word%0d actual=%0h required=%0h", mon_pos, din, exp_w);
            end
          end
          mon_pos = (mon_pos + 1) % TW;
        end else if (mon_pos != 0) begin
          checks++;
          errors++;
          $display("FAIL record_gap actual wr_en=0 required wr_en=1 at word %0d", mon_pos);
          mon_pos = 0;
        end
      end
    end
  end

  // Random FIFO-level pressure.
  initial begin
    forever begin
      @(posedge clk156);
      #1;
      if (pf_rand) prog_full = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic rand_beats(input int len);
    for (int k = 0; k < len; k++) begin
      bd[k] = {$urandom, $urandom};
      bk[k] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      bu[k] = ($urandom_range(0, 11) == 0);
    end
  endtask

  // Drive one TLP from bd/bk/bu; called just after a rising edge. Returns
  // the cycle numbers of the first and last accepting edges and the number
  // of cycles a beat waited for tready. Expected record pushed on tlast.
  task automatic send_tlp(input int len, output int first_edge, output int last_edge,
                          output int stalls);
    logic rdy, pf_s, acc, any_err, drop;
    logic [63:0] d;
    int e;
    stalls = 0; first_edge = 0; last_edge = 0; any_err = 1'b0; pf_s = 1'b0; e = 0;
    for (int k = 0; k < len; k++) begin
      acc = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = bd[k];
      s_axis_tkeep  = bk[k];
      s_axis_tlast  = (k == len - 1);
      s_axis_tuser  = bu[k];
      for (int w = 0; w < 300 && !acc; w++) begin
        @(negedge clk156);
        rdy  = s_axis_tready;
        pf_s = prog_full;
        e    = cyc;
        @(posedge clk156);
        if (rdy) acc = 1'b1;
        else stalls++;
      end
      #1;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no tready required=beat %0d accepted", k);
        s_axis_tvalid = 1'b0;
        return;
      end
      if (k == 0) first_edge = e;
      last_edge = e;
      if (bu[k]) any_err = 1'b1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    drop = DROP && pf_s;
    if (len > TW) trunc_exp++;
    if (drop) begin
      drop_exp++;
    end else begin
      for (int w = 0; w < TW; w++) begin
        d = (w < len) ? mask_beat(bd[w], bk[w]) : 64'h0;
        exp_q.push_back({8'hFF, d, (w == TW - 1), (w == TW - 1) && (any_err || len > TW)});
      end
      cap_exp++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk156);
    repeat (3) @(posedge clk156);
    #1;
    chk("records_drained", 74'(exp_q.size()), 74'd0);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_cap_count"}, cap_count, cap_exp);
    chk({tag, "_trunc_count"}, trunc_count, trunc_exp);
    chk({tag, "_drop_count"}, drop_count, drop_exp);
  endtask

  initial begin
    int f1, l1, f2, l2, st, len;
    bit seen;
    sys_rst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; prog_full = 1'b0;

    // Reset values, then tready rises on the first clock after release.
    repeat (3) @(posedge clk156);
    #1;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_din", din, 0);
    chk_counters("rst");
    sys_rst_n = 1'b1;
    @(negedge clk156);
    chk("tready_before_first_clk", s_axis_tready, 0);
    @(posedge clk156);
    #1;
    chk("tready_after_release", s_axis_tready, 1);

    // One-beat TLP with partial keep; writes start one cycle after tlast.
    bd[0] = 64'h1122334455667788; bk[0] = 8'h0F; bu[0] = 1'b0;
    send_tlp(1, f1, l1, st);
    @(negedge clk156);
    chk("write_latency", wr_en, 1);
    drain();
    chk_counters("one_beat");

    // Six-beat TLP: truncated to four words, tready held through all beats.
    rand_beats(6);
    for (int k = 0; k < 6; k++) bu[k] = 1'b0;
    send_tlp(6, f1, l1, st);
    chk("trunc_tready_stalls", 74'(st), 74'd0);
    drain();
    chk_counters("six_beat");

    // prog_full high at tlast, released ten cycles later.
    rand_beats(2);
    prog_full = 1'b1;
    send_tlp(2, f1, l1, st);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk156);
      chk("full_hold_tready", s_axis_tready, DROP ? 1 : 0);
      chk("full_hold_wr_en", wr_en, 0);
    end
    @(posedge clk156);
    #1;
    prog_full = 1'b0;
    @(negedge clk156);
    chk("wr_en_release_cycle", wr_en, 0);
    @(negedge clk156);
    chk("wr_en_after_release", wr_en, DROP ? 0 : 1);
    drain();
    chk_counters("full");

    // Back-to-back four-beat TLPs: tready low for exactly TW cycles between.
    rand_beats(4);
    send_tlp(4, f1, l1, st);
    rand_beats(4);
    send_tlp(4, f2, l2, st);
    chk("b2b_gap_edges", 74'(f2 - l1), 74'(TW + 1));
    drain();
    chk_counters("b2b");

    // Reset asserted during the second word of a record.
    rand_beats(4);
    send_tlp(4, f1, l1, st);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk156);
      seen = wr_en;
    end
    chk("reset_test_write_seen", seen, 1);
    @(posedge clk156);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midwrite_rst_wr_en", wr_en, 0);
    chk("midwrite_rst_din", din, 0);
    chk("midwrite_rst_tready", s_axis_tready, 0);
    exp_q.delete();
    mon_pos = 0;
    cap_exp = '0; trunc_exp = '0; drop_exp = '0;
    chk_counters("midwrite_rst");
    repeat (2) @(posedge clk156);
    #3;
    sys_rst_n = 1'b1;
    @(posedge clk156);
    #1;
    rand_beats(3);
    bu[1] = 1'b1;
    send_tlp(3, f1, l1, st);
    drain();
    chk_counters("after_rst");

    // Randomized traffic with random FIFO pressure.
    pf_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 7);
      rand_beats(len);
      send_tlp(len, f1, l1, st);
      repeat ($urandom_range(0, 2)) @(posedge clk156);
      #1;
    end
    pf_rand = 1'b0;
    @(posedge clk156);
    #2;
    prog_full = 1'b0;
    drain();
    chk_counters("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
